alarm_scheduler: RTL

//   Parametrised N-channel alarm engine for the digital clock top level. It replaces the four fixed
//   per-alarm instances with one block that holds the alarm table, detects triggers against
//   the running seconds-of-day, arbitrates concurrent alarms and supports snooze. Outputs
//   one active channel (index, music, remaining time) to the song player and display mux.

---
 rtl/alarm_scheduler_if.sv | 40 ++++
 rtl/alarm_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler_if.sv
// Bundles the alarm table access, trigger inputs and active-channel outputs
// between the clock top level (master) and the alarm scheduler (slave).
interface alarm_scheduler_if #(
  parameter int N_ALARM = 4,
  parameter int SEC_W   = 17
);
  localparam int IDX_W = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

  logic               tick_1hz;
  logic [SEC_W-1:0]   now_sec;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic               cfg_en;
  logic [SEC_W-1:0]   cfg_sec;
  logic [1:0]         cfg_len;
  logic [1:0]         cfg_music;
  logic               dismiss;
  logic               snooze;
  logic               rd_en;
  logic [SEC_W-1:0]   rd_sec;
  logic [1:0]         rd_len;
  logic [1:0]         rd_music;
  logic               ringing;
  logic [IDX_W-1:0]   ring_idx;
  logic [1:0]         ring_music;
  logic [7:0]         ring_left;
  logic [N_ALARM-1:0] pending;

  modport master (
    output tick_1hz, now_sec, cfg_we, cfg_idx, cfg_en, cfg_sec, cfg_len, cfg_music,
           dismiss, snooze,
    input  rd_en, rd_sec, rd_len, rd_music, ringing, ring_idx, ring_music, ring_left, pending
  );

  modport slave (
    input  tick_1hz, now_sec, cfg_we, cfg_idx, cfg_en, cfg_sec, cfg_len, cfg_music,
           dismiss, snooze,
    output rd_en, rd_sec, rd_len, rd_music, ringing, ring_idx, ring_music, ring_left, pending
  );
endinterface

// File: rtl/alarm_scheduler.sv
// N-channel alarm engine: alarm table, per-channel IDLE/RING/SNZ state machines,
// lowest-index arbitration of ringing channels and snooze with midnight wrap.
module alarm_scheduler #(
  parameter int N_ALARM     = 4,
  parameter int SEC_W       = 17,
  parameter int DAY_SECS    = 86400,
  parameter int LEN_UNIT    = 15,
  parameter int SNOOZE_SECS = 300
) (
  input logic               clk,
  input logic               rst,
  alarm_scheduler_if.slave  bus
);
  localparam int IDX_W = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RING = 2'd1;
  localparam logic [1:0] S_SNZ  = 2'd2;

  logic [N_ALARM-1:0] ring_mask;
  logic [N_ALARM-1:0] en_w;
  logic [SEC_W-1:0]   sec_w   [N_ALARM];
  logic [1:0]         len_w   [N_ALARM];
  logic [1:0]         music_w [N_ALARM];
  logic [7:0]         left_w  [N_ALARM];

  logic               act_any;
  logic [IDX_W-1:0]   act_idx;
  logic [SEC_W:0]     snz_sum;
  logic [SEC_W-1:0]   snz_target;

  // One extra bit so the wrap past midnight cannot overflow before the modulo.
  assign snz_sum    = {1'b0, bus.now_sec} + (SEC_W+1)'(SNOOZE_SECS);
  assign snz_target = (snz_sum >= (SEC_W+1)'(DAY_SECS)) ?
                      SEC_W'(snz_sum - (SEC_W+1)'(DAY_SECS)) : SEC_W'(snz_sum);

  always_comb begin
    act_any = 1'b0;
    act_idx = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (ring_mask[i]) begin
        act_any = 1'b1;
        act_idx = IDX_W'(i);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_ALARM; gi++) begin : g_ch
      logic [1:0]       state_reg;
      logic             en_reg;
      logic [SEC_W-1:0] sec_reg;
      logic [SEC_W-1:0] snz_reg;
      logic [1:0]       len_reg;
      logic [1:0]       music_reg;
      logic [7:0]       left_reg;
      logic             hit_cfg;
      logic             is_act;
      logic             at_alarm;
      logic [7:0]       full_len;

      assign hit_cfg  = bus.cfg_we && (bus.cfg_idx == IDX_W'(gi));
      assign is_act   = act_any && (act_idx == IDX_W'(gi));
      assign at_alarm = en_reg && (bus.now_sec == sec_reg);
      assign full_len = 8'((32'(len_reg) + 32'd1) * LEN_UNIT);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg <= S_IDLE;
          en_reg    <= 1'b0;
          sec_reg   <= '0;
          snz_reg   <= '0;
          len_reg   <= '0;
          music_reg <= '0;
          left_reg  <= '0;
        end else if (hit_cfg) begin
          // A table write always parks the channel, cancelling any ring or snooze.
          en_reg    <= bus.cfg_en;
          sec_reg   <= bus.cfg_sec;
          len_reg   <= bus.cfg_len;
          music_reg <= bus.cfg_music;
          state_reg <= S_IDLE;
          left_reg  <= '0;
        end else begin
          case (state_reg)
            S_IDLE: begin
              if (bus.tick_1hz && at_alarm) begin
                state_reg <= S_RING;
                left_reg  <= full_len;
              end
            end
            S_RING: begin
              if (is_act && bus.dismiss) begin
                state_reg <= S_IDLE;
                left_reg  <= '0;
              end else if (is_act && bus.snooze) begin
                state_reg <= S_SNZ;
                snz_reg   <= snz_target;
              end else if (bus.tick_1hz) begin
                if (left_reg <= 8'd1) begin
                  state_reg <= S_IDLE;
                  left_reg  <= '0;
                end else begin
                  left_reg <= left_reg - 8'd1;
                end
              end
            end
            S_SNZ: begin
              if (!en_reg) begin
                state_reg <= S_IDLE;
              end else if (bus.tick_1hz && (bus.now_sec == snz_reg)) begin
                state_reg <= S_RING;
                left_reg  <= full_len;
              end
            end
            default: state_reg <= S_IDLE;
          endcase
        end
      end

      assign ring_mask[gi] = (state_reg == S_RING);
      assign en_w[gi]      = en_reg;
      assign sec_w[gi]     = sec_reg;
      assign len_w[gi]     = len_reg;
      assign music_w[gi]   = music_reg;
      assign left_w[gi]    = left_reg;
    end
  endgenerate

  logic               ringing_reg;
  logic [IDX_W-1:0]   ring_idx_reg;
  logic [1:0]         ring_music_reg;
  logic [7:0]         ring_left_reg;
  logic [N_ALARM-1:0] pending_reg;
  logic               rd_en_reg;
  logic [SEC_W-1:0]   rd_sec_reg;
  logic [1:0]         rd_len_reg;
  logic [1:0]         rd_music_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ringing_reg    <= 1'b0;
      ring_idx_reg   <= '0;
      ring_music_reg <= '0;
      ring_left_reg  <= '0;
      pending_reg    <= '0;
      rd_en_reg      <= 1'b0;
      rd_sec_reg     <= '0;
      rd_len_reg     <= '0;
      rd_music_reg   <= '0;
    end else begin
      ringing_reg    <= act_any;
      ring_idx_reg   <= act_any ? act_idx : '0;
      ring_music_reg <= act_any ? music_w[act_idx] : 2'd0;
      ring_left_reg  <= act_any ? left_w[act_idx] : 8'd0;
      pending_reg    <= ring_mask;
      rd_en_reg      <= en_w[bus.cfg_idx];
      rd_sec_reg     <= sec_w[bus.cfg_idx];
      rd_len_reg     <= len_w[bus.cfg_idx];
      rd_music_reg   <= music_w[bus.cfg_idx];
    end
  end

  assign bus.ringing    = ringing_reg;
  assign bus.ring_idx   = ring_idx_reg;
  assign bus.ring_music = ring_music_reg;
  assign bus.ring_left  = ring_left_reg;
  assign bus.pending    = pending_reg;
  assign bus.rd_en      = rd_en_reg;
  assign bus.rd_sec     = rd_sec_reg;
  assign bus.rd_len     = rd_len_reg;
  assign bus.rd_music   = rd_music_reg;
endmodule
